// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Purpose : Bundles every signal between the memory-access stage and its
//           neighbours (execute, data memory, writeback) into one interface.
// Modports:
//   master - the environment around the stage: drives the execute inputs,
//            FLUSH and the data-memory response; observes everything else.
//   slave  - the mem_stage itself.
// Signal groups:
//   Execute -> stage : MEM_V, MEM_NPC, MEM_ALU_RESULT, MEM_SR2, MEM_CSRFD,
//                      MEM_RFD, MEM_IR, MEM_DRID, MEM_PC_MUX, MEM_ECALL, FLUSH
//   Stage -> execute : MEM_STALL
//   Stage <-> dmem   : DMEM_REQ/WE/ADDR/WDATA/WSTRB out, DMEM_ACK/ERR/RDATA in
//   Stage -> wb      : WB_V, WB_* bundle, MEM_LAM/LAF/SAM/SAF, WB_MEM_ADDR
// Handshakes:
//   Execute: an instruction transfers on a rising edge where MEM_V=1 and
//   MEM_STALL=0 (and FLUSH=0); execute holds its outputs while MEM_STALL=1.
//   Dmem: DMEM_REQ and its qualifiers stay constant until the edge on which
//   DMEM_ACK=1 is sampled; DMEM_ERR and DMEM_RDATA are meaningful only then.
//   Writeback: WB_V is a one-cycle pulse per bundle; no back-pressure.
// ---------------------------------------------------------------------------
interface mem_stage_if;
    logic        MEM_V;
    logic [63:0] MEM_NPC;
    logic [63:0] MEM_ALU_RESULT;
    logic [63:0] MEM_SR2;
    logic [63:0] MEM_CSRFD;
    logic [63:0] MEM_RFD;
    logic [31:0] MEM_IR;
    logic [4:0]  MEM_DRID;
    logic        MEM_PC_MUX;
    logic        MEM_ECALL;
    logic        FLUSH;
    logic        MEM_STALL;

    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [63:0] DMEM_ADDR;
    logic [63:0] DMEM_WDATA;
    logic [7:0]  DMEM_WSTRB;
    logic        DMEM_ACK;
    logic        DMEM_ERR;
    logic [63:0] DMEM_RDATA;

    logic        WB_V;
    logic [63:0] WB_NPC;
    logic [63:0] WB_MEM_RESULT;
    logic [63:0] WB_ALU_RESULT;
    logic [63:0] WB_CSRFD;
    logic [63:0] WB_RFD;
    logic [31:0] WB_IR;
    logic [4:0]  WB_DRID;
    logic        WB_PC_MUX;
    logic        WB_ECALL;
    logic        MEM_LAM;
    logic        MEM_LAF;
    logic        MEM_SAM;
    logic        MEM_SAF;
    logic [63:0] WB_MEM_ADDR;

    modport master (
        output MEM_V, MEM_NPC, MEM_ALU_RESULT, MEM_SR2, MEM_CSRFD, MEM_RFD,
               MEM_IR, MEM_DRID, MEM_PC_MUX, MEM_ECALL, FLUSH,
               DMEM_ACK, DMEM_ERR, DMEM_RDATA,
        input  MEM_STALL, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB,
               WB_V, WB_NPC, WB_MEM_RESULT, WB_ALU_RESULT, WB_CSRFD, WB_RFD,
               WB_IR, WB_DRID, WB_PC_MUX, WB_ECALL,
               MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF, WB_MEM_ADDR
    );

    modport slave (
        input  MEM_V, MEM_NPC, MEM_ALU_RESULT, MEM_SR2, MEM_CSRFD, MEM_RFD,
               MEM_IR, MEM_DRID, MEM_PC_MUX, MEM_ECALL, FLUSH,
               DMEM_ACK, DMEM_ERR, DMEM_RDATA,
        output MEM_STALL, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB,
               WB_V, WB_NPC, WB_MEM_RESULT, WB_ALU_RESULT, WB_CSRFD, WB_RFD,
               WB_IR, WB_DRID, WB_PC_MUX, WB_ECALL,
               MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF, WB_MEM_ADDR
    );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Purpose : Memory-access pipeline stage between execute and writeback.
//           Accepts one instruction per handshake, checks alignment, issues
//           one load/store at a time with byte strobes, extracts and extends
//           load data, and registers a WB_* bundle with exception flags.
// Ports   : CLK   - clock, rising edge
//           RESET - asynchronous active-low reset
//           bus   - mem_stage_if.slave (execute, dmem and writeback signals)
// Params  : TIMEOUT_CYCLES - watchdog limit in WAIT cycles
// Macro   : MEM_TIMEOUT_EN - when defined, a watchdog completes a stuck
//           access as an access fault after TIMEOUT_CYCLES WAIT cycles.
// State   : IDLE / WAIT, visible externally as MEM_STALL.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         CLK,
    input  logic         RESET,
    mem_stage_if.slave   bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    typedef struct packed {
        logic [63:0] npc;
        logic [63:0] alu;
        logic [63:0] csrfd;
        logic [63:0] rfd;
        logic [31:0] ir;
        logic [4:0]  drid;
        logic        pc_mux;
        logic        ecall;
    } bundle_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    bundle_t     hold_q, hold_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    bundle_t     wb_q, wb_d;
    logic [63:0] wb_res_q, wb_res_d;
    logic [63:0] wb_addr_q, wb_addr_d;
    logic        wb_v_q, wb_v_d;
    logic        lam_q, lam_d, laf_q, laf_d, sam_q, sam_d, saf_q, saf_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Decode of the instruction presented by execute (used only at accept).
    bundle_t     in_b;
    logic [2:0]  in_f3;
    logic [2:0]  in_off;
    logic        in_load, in_store, in_mis;
    logic [7:0]  in_mask;

    assign in_b = '{npc: bus.MEM_NPC, alu: bus.MEM_ALU_RESULT,
                    csrfd: bus.MEM_CSRFD, rfd: bus.MEM_RFD, ir: bus.MEM_IR,
                    drid: bus.MEM_DRID, pc_mux: bus.MEM_PC_MUX,
                    ecall: bus.MEM_ECALL};
    assign in_f3    = bus.MEM_IR[14:12];
    assign in_off   = bus.MEM_ALU_RESULT[2:0];
    // funct3 111 is not a defined load, and stores only use 000-011; such
    // encodings fall through as non-memory instructions.
    assign in_load  = (bus.MEM_IR[6:0] == OP_LOAD) && (in_f3 != 3'b111);
    assign in_store = (bus.MEM_IR[6:0] == OP_STORE) && !in_f3[2];

    always_comb begin
        in_mis  = 1'b0;
        in_mask = 8'h01;
        case (in_f3[1:0])
            2'd1: begin in_mis = in_off[0];      in_mask = 8'h03; end
            2'd2: begin in_mis = |in_off[1:0];   in_mask = 8'h0F; end
            2'd3: begin in_mis = |in_off;        in_mask = 8'hFF; end
            default: begin in_mis = 1'b0;        in_mask = 8'h01; end
        endcase
    end

    // Load data extraction from the held instruction and address.
    logic [63:0] ld_shift, ld_data;
    assign ld_shift = bus.DMEM_RDATA >> {hold_q.alu[2:0], 3'b000};

    always_comb begin
        ld_data = ld_shift;
        case (hold_q.ir[14:12])
            3'b000:  ld_data = {{56{ld_shift[7]}},  ld_shift[7:0]};
            3'b001:  ld_data = {{48{ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_data = {{32{ld_shift[31]}}, ld_shift[31:0]};
            3'b100:  ld_data = {56'd0, ld_shift[7:0]};
            3'b101:  ld_data = {48'd0, ld_shift[15:0]};
            3'b110:  ld_data = {32'd0, ld_shift[31:0]};
            default: ld_data = ld_shift;
        endcase
    end

    logic done, err;

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        hold_d    = hold_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wb_d      = wb_q;
        wb_res_d  = wb_res_q;
        wb_addr_d = wb_addr_q;
        wb_v_d    = 1'b0;
        lam_d     = 1'b0;
        laf_d     = 1'b0;
        sam_d     = 1'b0;
        saf_d     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.MEM_V && !bus.FLUSH) begin
                    hold_d = in_b;
                    if ((in_load || in_store) && !in_mis) begin
                        state_d = WAIT;
                        kill_d  = 1'b0;
                        req_d   = 1'b1;
                        we_d    = in_store;
                        addr_d  = {bus.MEM_ALU_RESULT[63:3], 3'b000};
                        wdata_d = bus.MEM_SR2 << {in_off, 3'b000};
                        wstrb_d = in_mask << in_off;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        // Non-memory or misaligned: bundle completes now.
                        wb_v_d    = 1'b1;
                        wb_d      = in_b;
                        wb_res_d  = 64'd0;
                        wb_addr_d = bus.MEM_ALU_RESULT;
                        lam_d     = in_load && in_mis;
                        sam_d     = in_store && in_mis;
                    end
                end
            end
            WAIT: begin
                if (bus.FLUSH) kill_d = 1'b1;
                done = bus.DMEM_ACK;
                err  = bus.DMEM_ACK && bus.DMEM_ERR;
`ifdef MEM_TIMEOUT_EN
                if (!bus.DMEM_ACK) begin
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                if (done) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    kill_d    = 1'b0;
                    wb_d      = hold_q;
                    wb_addr_d = hold_q.alu;
                    wb_res_d  = (!we_q && !err) ? ld_data : 64'd0;
                    // A flush seen at any point during the access squashes it.
                    if (!(kill_q || bus.FLUSH)) begin
                        wb_v_d = 1'b1;
                        laf_d  = !we_q && err;
                        saf_d  = we_q && err;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            kill_q    <= 1'b0;
            hold_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            wstrb_q   <= 8'd0;
            wb_q      <= '0;
            wb_res_q  <= 64'd0;
            wb_addr_q <= 64'd0;
            wb_v_q    <= 1'b0;
            lam_q     <= 1'b0;
            laf_q     <= 1'b0;
            sam_q     <= 1'b0;
            saf_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            hold_q    <= hold_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wb_q      <= wb_d;
            wb_res_q  <= wb_res_d;
            wb_addr_q <= wb_addr_d;
            wb_v_q    <= wb_v_d;
            lam_q     <= lam_d;
            laf_q     <= laf_d;
            sam_q     <= sam_d;
            saf_q     <= saf_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.MEM_STALL     = (state_q == WAIT);
    assign bus.DMEM_REQ      = req_q;
    assign bus.DMEM_WE       = we_q;
    assign bus.DMEM_ADDR     = addr_q;
    assign bus.DMEM_WDATA    = wdata_q;
    assign bus.DMEM_WSTRB    = wstrb_q;
    assign bus.WB_V          = wb_v_q;
    assign bus.WB_NPC        = wb_q.npc;
    assign bus.WB_MEM_RESULT = wb_res_q;
    assign bus.WB_ALU_RESULT = wb_q.alu;
    assign bus.WB_CSRFD      = wb_q.csrfd;
    assign bus.WB_RFD        = wb_q.rfd;
    assign bus.WB_IR         = wb_q.ir;
    assign bus.WB_DRID       = wb_q.drid;
    assign bus.WB_PC_MUX     = wb_q.pc_mux;
    assign bus.WB_ECALL      = wb_q.ecall;
    assign bus.MEM_LAM       = lam_q;
    assign bus.MEM_LAF       = laf_q;
    assign bus.MEM_SAM       = sam_q;
    assign bus.MEM_SAF       = saf_q;
    assign bus.WB_MEM_ADDR   = wb_addr_q;
endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage: drives the execute and dmem sides through the
// interface, compares outputs against hand-computed values one edge at a time.
// Inputs change 1ns after each rising edge; outputs are sampled at that time.
// ---------------------------------------------------------------------------
module tb_mem_stage;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "bench time limit");
    end

    // Driver helpers
    function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.MEM_V          = 1'b0;
        bus.MEM_NPC        = 64'd0;
        bus.MEM_ALU_RESULT = 64'd0;
        bus.MEM_SR2        = 64'd0;
        bus.MEM_CSRFD      = 64'd0;
        bus.MEM_RFD        = 64'd0;
        bus.MEM_IR         = 32'd0;
        bus.MEM_DRID       = 5'd0;
        bus.MEM_PC_MUX     = 1'b0;
        bus.MEM_ECALL      = 1'b0;
        bus.FLUSH          = 1'b0;
        bus.DMEM_ACK       = 1'b0;
        bus.DMEM_ERR       = 1'b0;
        bus.DMEM_RDATA     = 64'd0;
    endtask

    // Presents an instruction for one accept edge, then drops MEM_V.
    task automatic issue(input logic [31:0] ir, input logic [63:0] addr, input logic [63:0] sr2);
        bus.MEM_V          = 1'b1;
        bus.MEM_IR         = ir;
        bus.MEM_ALU_RESULT = addr;
        bus.MEM_SR2        = sr2;
        tick();
        bus.MEM_V          = 1'b0;
    endtask

    // One-cycle dmem response.
    task automatic ack_once(input logic [63:0] rdata, input logic err);
        bus.DMEM_ACK   = 1'b1;
        bus.DMEM_ERR   = err;
        bus.DMEM_RDATA = rdata;
        tick();
        bus.DMEM_ACK   = 1'b0;
        bus.DMEM_ERR   = 1'b0;
    endtask

    // Scoreboard comparison
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 64'(bus.MEM_STALL), 64'd0);
        chk("rst_req",   64'(bus.DMEM_REQ), 64'd0);
        chk("rst_wbv",   64'(bus.WB_V), 64'd0);
        chk("rst_wstrb", 64'(bus.DMEM_WSTRB), 64'd0);
        chk("rst_res",   bus.WB_MEM_RESULT, 64'd0);
        rst_n = 1'b1;
        tick();

        // LW at 0x1004, ACK in the first WAIT cycle
        issue(mk_ir(OP_LOAD, 3'b010), 64'h1004, 64'd0);
        chk("lw_stall", 64'(bus.MEM_STALL), 64'd1);
        chk("lw_req",   64'(bus.DMEM_REQ), 64'd1);
        chk("lw_we",    64'(bus.DMEM_WE), 64'd0);
        chk("lw_addr",  bus.DMEM_ADDR, 64'h1000);
        chk("lw_wstrb", 64'(bus.DMEM_WSTRB), 64'hF0);
        chk("lw_wbv0",  64'(bus.WB_V), 64'd0);
        ack_once(64'h80000000_00000000, 1'b0);
        chk("lw_wbv",   64'(bus.WB_V), 64'd1);
        chk("lw_res",   bus.WB_MEM_RESULT, 64'hFFFFFFFF_80000000);
        chk("lw_stall0", 64'(bus.MEM_STALL), 64'd0);
        chk("lw_req0",  64'(bus.DMEM_REQ), 64'd0);
        chk("lw_laf",   64'(bus.MEM_LAF), 64'd0);
        tick();
        chk("lw_pulse", 64'(bus.WB_V), 64'd0);

        // LWU, same stimulus
        issue(mk_ir(OP_LOAD, 3'b110), 64'h1004, 64'd0);
        ack_once(64'h80000000_00000000, 1'b0);
        chk("lwu_wbv", 64'(bus.WB_V), 64'd1);
        chk("lwu_res", bus.WB_MEM_RESULT, 64'h00000000_80000000);

        // SH at 0x2006, ACK in the fourth WAIT cycle
        issue(mk_ir(OP_STORE, 3'b001), 64'h2006, 64'hABCD);
        repeat (3) begin
            chk("sh_stall", 64'(bus.MEM_STALL), 64'd1);
            tick();
        end
        chk("sh_stall4", 64'(bus.MEM_STALL), 64'd1);
        chk("sh_we",     64'(bus.DMEM_WE), 64'd1);
        chk("sh_addr",   bus.DMEM_ADDR, 64'h2000);
        chk("sh_wstrb",  64'(bus.DMEM_WSTRB), 64'hC0);
        chk("sh_wdata",  bus.DMEM_WDATA, 64'hABCD0000_00000000);
        ack_once(64'd0, 1'b0);
        chk("sh_wbv",    64'(bus.WB_V), 64'd1);
        chk("sh_saf",    64'(bus.MEM_SAF), 64'd0);
        chk("sh_stall0", 64'(bus.MEM_STALL), 64'd0);
        chk("sh_res",    bus.WB_MEM_RESULT, 64'd0);

        // LD misaligned at 0x3004
        issue(mk_ir(OP_LOAD, 3'b011), 64'h3004, 64'd0);
        chk("ld_req",   64'(bus.DMEM_REQ), 64'd0);
        chk("ld_stall", 64'(bus.MEM_STALL), 64'd0);
        chk("ld_wbv",   64'(bus.WB_V), 64'd1);
        chk("ld_lam",   64'(bus.MEM_LAM), 64'd1);
        chk("ld_laf",   64'(bus.MEM_LAF), 64'd0);
        chk("ld_maddr", bus.WB_MEM_ADDR, 64'h3004);
        tick();
        chk("ld_wbv0",  64'(bus.WB_V), 64'd0);
        chk("ld_lam0",  64'(bus.MEM_LAM), 64'd0);

        // SD with ACK+ERR
        issue(mk_ir(OP_STORE, 3'b011), 64'h4000, 64'h11223344_55667788);
        chk("sd_wstrb", 64'(bus.DMEM_WSTRB), 64'hFF);
        chk("sd_wdata", bus.DMEM_WDATA, 64'h11223344_55667788);
        ack_once(64'd0, 1'b1);
        chk("sd_wbv",   64'(bus.WB_V), 64'd1);
        chk("sd_saf",   64'(bus.MEM_SAF), 64'd1);
        chk("sd_laf",   64'(bus.MEM_LAF), 64'd0);
        tick();
        chk("sd_saf0",  64'(bus.MEM_SAF), 64'd0);

        // LH at 0x6002: halfword 0x8001 sign-extended
        issue(mk_ir(OP_LOAD, 3'b001), 64'h6002, 64'd0);
        chk("lh_wstrb", 64'(bus.DMEM_WSTRB), 64'h0C);
        ack_once(64'h00000000_80010000, 1'b0);
        chk("lh_res",   bus.WB_MEM_RESULT, 64'hFFFFFFFF_FFFF8001);

        // LB at 0x5003 flushed during WAIT, then completes with ERR
        issue(mk_ir(OP_LOAD, 3'b000), 64'h5003, 64'd0);
        bus.FLUSH = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
        chk("lbf_stall", 64'(bus.MEM_STALL), 64'd1);
        ack_once(64'h00000000_FF000000, 1'b1);
        chk("lbf_wbv",   64'(bus.WB_V), 64'd0);
        chk("lbf_laf",   64'(bus.MEM_LAF), 64'd0);
        chk("lbf_lam",   64'(bus.MEM_LAM), 64'd0);
        chk("lbf_stall0", 64'(bus.MEM_STALL), 64'd0);
        chk("lbf_req",   64'(bus.DMEM_REQ), 64'd0);

        // ADDI back-to-back with LW
        bus.MEM_V          = 1'b1;
        bus.MEM_IR         = mk_ir(OP_IMM, 3'b000);
        bus.MEM_ALU_RESULT = 64'h1234;
        bus.MEM_DRID       = 5'd5;
        tick();
        chk("addi_wbv",   64'(bus.WB_V), 64'd1);
        chk("addi_alu",   bus.WB_ALU_RESULT, 64'h1234);
        chk("addi_res",   bus.WB_MEM_RESULT, 64'd0);
        chk("addi_drid",  64'(bus.WB_DRID), 64'd5);
        chk("addi_stall", 64'(bus.MEM_STALL), 64'd0);
        bus.MEM_IR         = mk_ir(OP_LOAD, 3'b010);
        bus.MEM_ALU_RESULT = 64'h1008;
        tick();
        bus.MEM_V = 1'b0;
        chk("b2b_stall", 64'(bus.MEM_STALL), 64'd1);
        chk("b2b_req",   64'(bus.DMEM_REQ), 64'd1);
        chk("b2b_addr",  bus.DMEM_ADDR, 64'h1008);
        chk("b2b_wbv",   64'(bus.WB_V), 64'd0);
        ack_once(64'h00000000_7FFF0001, 1'b0);
        chk("b2b_res",   bus.WB_MEM_RESULT, 64'h00000000_7FFF0001);
        chk("b2b_drid",  64'(bus.WB_DRID), 64'd5);

        // FLUSH in IDLE blocks accept
        bus.MEM_V  = 1'b1;
        bus.FLUSH  = 1'b1;
        bus.MEM_IR = mk_ir(OP_IMM, 3'b000);
        tick();
        bus.MEM_V = 1'b0;
        bus.FLUSH = 1'b0;
        chk("fli_wbv",   64'(bus.WB_V), 64'd0);
        chk("fli_stall", 64'(bus.MEM_STALL), 64'd0);

        // Reset mid-WAIT, then a stray ACK
        issue(mk_ir(OP_LOAD, 3'b010), 64'h7000, 64'd0);
        chk("rw_stall", 64'(bus.MEM_STALL), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_stall0", 64'(bus.MEM_STALL), 64'd0);
        chk("rw_req",    64'(bus.DMEM_REQ), 64'd0);
        chk("rw_addr",   bus.DMEM_ADDR, 64'd0);
        chk("rw_wbalu",  bus.WB_ALU_RESULT, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_once(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("rw_lateack_wbv", 64'(bus.WB_V), 64'd0);
        chk("rw_lateack_stall", 64'(bus.MEM_STALL), 64'd0);
        chk("rw_lateack_req", 64'(bus.DMEM_REQ), 64'd0);

`ifdef MEM_TIMEOUT_EN
        // Watchdog: no ACK, access completes as a load fault after 4 WAIT cycles
        issue(mk_ir(OP_LOAD, 3'b010), 64'h8000, 64'd0);
        repeat (3) begin
            chk("to_wait", 64'(bus.MEM_STALL), 64'd1);
            tick();
        end
        chk("to_wait4", 64'(bus.MEM_STALL), 64'd1);
        tick();
        chk("to_wbv",   64'(bus.WB_V), 64'd1);
        chk("to_laf",   64'(bus.MEM_LAF), 64'd1);
        chk("to_stall", 64'(bus.MEM_STALL), 64'd0);
        chk("to_req",   64'(bus.DMEM_REQ), 64'd0);
        ack_once(64'd0, 1'b0);
        chk("to_stray", 64'(bus.WB_V), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
